// File: rtl/tmeasure_multi_pkg.sv
// Shared types for the multi-channel period/pulse-width meter.
// Optional timeout feature is enabled by defining TMEAS_TIMEOUT_EN.
package tmeasure_pkg;

  typedef enum logic [1:0] {
    M_PERIOD = 2'd0,
    M_HIGH   = 2'd1,
    M_LOW    = 2'd2
  } mode_t;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    ARM  = 4'b0010,
    RUN  = 4'b0100,
    DONE = 4'b1000
  } top_state_t;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_WAIT  = 2'd1,
    C_COUNT = 2'd2,
    C_DONE  = 2'd3
  } chan_state_t;

  // Reserved encoding 3 measures the full period.
  function automatic mode_t decode_mode(
    input logic [1:0] m
  );
    mode_t r;
    case (m)
      2'd1:    r = M_HIGH;
      2'd2:    r = M_LOW;
      default: r = M_PERIOD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmeasure_multi_if.sv
// Host handshake and result bus of the period/pulse-width meter.
// master = frequency-meter host, slave = tmeasure_multi.
interface tmeasure_multi_if #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 32,
  parameter int NPER_W = 8
) ();

  logic                        start;
  logic [1:0]                  mode;
  logic [NPER_W-1:0]           nper;
  logic                        abort;
  logic                        busy;
  logic                        done;
  logic [NCH-1:0][CNT_W-1:0]   val;
  logic [NCH-1:0]              ovf;
  logic [NCH-1:0]              tmo;

  modport master (
    output start, mode, nper, abort,
    input  busy, done, val, ovf, tmo
  );

  modport slave (
    input  start, mode, nper, abort,
    output busy, done, val, ovf, tmo
  );

endinterface

// File: rtl/tmeasure_multi_channel.sv
// One measured wave: 2-FF synchroniser, edge detect, channel FSM,
// saturating cycle accumulator with sticky overflow and timeout flags.
module tmeasure_channel
  import tmeasure_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int NPER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wave_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              force_i,
  input  mode_t             mode_i,
  input  logic [NPER_W-1:0] nper_i,
  output logic              done_o,
  output logic [CNT_W-1:0]  val_o,
  output logic              ovf_o,
  output logic              tmo_o
);

  logic        s1_q;
  logic        s2_q;
  logic        s3_q;
  logic        rise;
  logic        last;
  logic        inc;

  chan_state_t st_q;
  chan_state_t st_d;

  logic [NPER_W-1:0] edge_q;
  logic [NPER_W-1:0] edge_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              tmo_q;
  logic              tmo_d;

  // s2_q is the synchronised wave, s3_q its one-cycle delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= wave_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign last = rise &&
    ({1'b0, edge_q} + 1'b1 == {1'b0, nper_i});

  assign inc = (mode_i == M_PERIOD)
             | ((mode_i == M_HIGH) & s2_q)
             | ((mode_i == M_LOW) & ~s2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= C_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    if (abort_i) begin
      st_d = C_IDLE;
    end else if (start_i) begin
      st_d = C_WAIT;
    end else if (force_i && st_q != C_DONE) begin
      st_d = C_DONE;
    end else begin
      case (st_q)
        C_WAIT:  if (rise) st_d = C_COUNT;
        C_COUNT: if (last) st_d = C_DONE;
        default: st_d = st_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      edge_q <= edge_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      tmo_q  <= tmo_d;
    end
  end

  // Abort freezes the partial result; start clears it.
  always_comb begin
    edge_d = edge_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    tmo_d  = tmo_q;
    if (abort_i) begin
      edge_d = edge_q;
    end else if (start_i) begin
      edge_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      tmo_d  = 1'b0;
    end else if (force_i && st_q != C_DONE) begin
      tmo_d = 1'b1;
    end else if (st_q == C_COUNT) begin
      if (rise) edge_d = edge_q + 1'b1;
      if (inc) begin
        if (cnt_q == '1) ovf_d = 1'b1;
        else             cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign done_o = (st_q == C_DONE);
  assign val_o  = cnt_q;
  assign ovf_o  = ovf_q;
  assign tmo_o  = tmo_q;

endmodule

// File: rtl/tmeasure_multi.sv
// Multi-channel period/pulse-width meter: host handshake FSM over NCH channels.
// Define TMEAS_TIMEOUT_EN to add the RUN-state cycle limit (TIMEOUT_CYC).
module tmeasure_multi
  import tmeasure_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int CNT_W  = 32,
  parameter int NPER_W = 8
`ifdef TMEAS_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 2**24
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     wave,
  tmeasure_multi_if.slave    bus
);

  top_state_t state_q;
  top_state_t state_d;

  mode_t             mode_q;
  logic [NPER_W-1:0] nper_q;

  logic accept;
  logic chan_start;
  logic chan_abort;
  logic tmo_force;

  logic [NCH-1:0]            chan_done;
  logic [NCH-1:0][CNT_W-1:0] val_w;
  logic [NCH-1:0]            ovf_w;
  logic [NCH-1:0]            tmo_w;

  assign accept = (state_q == IDLE) & bus.start & ~bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): if (accept) state_d = ARM;
      (state_q == ARM):  state_d = bus.abort ? IDLE : RUN;
      (state_q == RUN): begin
        if (bus.abort)        state_d = IDLE;
        else if (&chan_done)  state_d = DONE;
      end
      (state_q == DONE): state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = 1'b1;
    bus.done   = 1'b0;
    chan_start = 1'b0;
    chan_abort = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): bus.busy = 1'b0;
      (state_q == ARM): begin
        chan_start = 1'b1;
        chan_abort = bus.abort;
      end
      (state_q == RUN):  chan_abort = bus.abort;
      (state_q == DONE): bus.done = 1'b1;
      default:           bus.busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_PERIOD;
      nper_q <= '0;
    end else if (accept) begin
      mode_q <= decode_mode(bus.mode);
      nper_q <= (bus.nper == '0) ? NPER_W'(1) : bus.nper;
    end
  end

`ifdef TMEAS_TIMEOUT_EN
  logic [31:0] run_cnt_q;
  logic [31:0] run_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (state_q == ARM)      run_cnt_d = '0;
    else if (state_q == RUN) run_cnt_d = run_cnt_q + 32'd1;
  end

  // Fires on the TIMEOUT_CYC-th RUN cycle.
  assign tmo_force = (state_q == RUN) && !bus.abort &&
                     (run_cnt_q == 32'(TIMEOUT_CYC - 1));
`else
  assign tmo_force = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tmeasure_channel #(
      .CNT_W  (CNT_W),
      .NPER_W (NPER_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .wave_i  (wave[i]),
      .start_i (chan_start),
      .abort_i (chan_abort),
      .force_i (tmo_force),
      .mode_i  (mode_q),
      .nper_i  (nper_q),
      .done_o  (chan_done[i]),
      .val_o   (val_w[i]),
      .ovf_o   (ovf_w[i]),
      .tmo_o   (tmo_w[i])
    );
  end

  assign bus.val = val_w;
  assign bus.ovf = ovf_w;
  assign bus.tmo = tmo_w;

endmodule

// File: tb/tb_tmeasure_multi.sv
// Bench for tmeasure_multi: directed waves, spec-level result model,
// per-cycle handshake compare plus literal end-of-test checks.
`timescale 1ns/1ps
module tb_tmeasure_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] wv = '0;
  int per[3];
  int hi[3];
  int ph[3];

  tmeasure_multi_if #(.NCH(2), .CNT_W(32), .NPER_W(8)) bus ();
  tmeasure_multi_if #(.NCH(1), .CNT_W(8),  .NPER_W(8)) bus8 ();

  tmeasure_multi #(
    .NCH(2), .CNT_W(32), .NPER_W(8)
`ifdef TMEAS_TIMEOUT_EN
    , .TIMEOUT_CYC(1000)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wave  (wv[1:0]),
    .bus   (bus)
  );

  tmeasure_multi #(
    .NCH(1), .CNT_W(8), .NPER_W(8)
  ) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .wave  (wv[2:2]),
    .bus   (bus8)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int cyc     = 0;
  int done_cyc = 0;

  longint exp_v[2];
  bit     exp_o[2];
  bit     exp_t[2];
  bit     exp_armed = 1'b0;
  bit     m_busy = 1'b0;
  bit     prev_done = 1'b0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Cycles accumulated over n periods, straight from the mode rules.
  function automatic longint model_val(input int md, input int p,
      input int h, input int n, input int w);
    longint pc;
    longint tot;
    longint mx;
    int nn;
    nn = (n == 0) ? 1 : n;
    if (p == 0) return 0;
    case (md)
      1:       pc = h;
      2:       pc = p - h;
      default: pc = p;
    endcase
    tot = pc * nn;
    mx  = (longint'(1) << w) - 1;
    return (tot > mx) ? mx : tot;
  endfunction

  function automatic bit model_ovf(input int md, input int p,
      input int h, input int n, input int w);
    longint pc;
    int nn;
    nn = (n == 0) ? 1 : n;
    if (p == 0) return 1'b0;
    case (md)
      1:       pc = h;
      2:       pc = p - h;
      default: pc = p;
    endcase
    return (pc * nn) > ((longint'(1) << w) - 1);
  endfunction

  // Square waves, changed away from the sampling edge.
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (per[c] == 0) begin
        wv[c] = 1'b0;
        ph[c] = 0;
      end else begin
        wv[c] = (ph[c] < hi[c]);
        ph[c] = (ph[c] + 1 >= per[c]) ? 0 : ph[c] + 1;
      end
    end
  end

  always @(posedge clk) cyc++;

  // Handshake model: busy follows accepted start, drops after done/abort.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      m_busy <= 1'b0;
    else if (m_busy) m_busy <= !(bus.abort || bus.done);
    else             m_busy <= bus.start && !bus.abort;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", longint'(bus.busy), longint'(m_busy));
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
        n_tests++;
        if (!exp_armed || prev_done) begin
          n_fail++;
          $display("FAIL done_pulse: got done=1 expected 0");
        end
        for (int c = 0; c < 2; c++) begin
          chk($sformatf("val%0d", c), longint'(bus.val[c]), exp_v[c]);
          chk($sformatf("ovf%0d", c), longint'(bus.ovf[c]),
              longint'(exp_o[c]));
          chk($sformatf("tmo%0d", c), longint'(bus.tmo[c]),
              longint'(exp_t[c]));
        end
        exp_armed = 1'b0;
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic pulse_start(input int md, input int n);
    @(posedge clk);
    #1;
    bus.mode  = 2'(md);
    bus.nper  = 8'(n);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic measure(input int md, input int n, input bit [1:0] tmask,
                         input int budget);
    int d0;
    int i;
    for (int c = 0; c < 2; c++) begin
      exp_v[c] = tmask[c] ? 0 : model_val(md, per[c], hi[c], n, 32);
      exp_o[c] = tmask[c] ? 1'b0 : model_ovf(md, per[c], hi[c], n, 32);
      exp_t[c] = tmask[c];
    end
    exp_armed = 1'b1;
    d0 = n_done;
    pulse_start(md, n);
    i = 0;
    while (n_done == d0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("done_seen", longint'(n_done - d0), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, longint'(bus.busy), 0);
    chk({nm, "_done"}, longint'(bus.done), 0);
    chk({nm, "_val0"}, longint'(bus.val[0]), 0);
    chk({nm, "_val1"}, longint'(bus.val[1]), 0);
    chk({nm, "_ovf"},  longint'(bus.ovf), 0);
    chk({nm, "_tmo"},  longint'(bus.tmo), 0);
  endtask

  task automatic test_basic(input string nm);
    int d0;
    per[0] = 10; hi[0] = 5;
    per[1] = 24; hi[1] = 12;
    repeat (30) @(negedge clk);
    measure(0, 4, 2'b00, 400);
    d0 = n_done;
    chk({nm, "_val0"}, longint'(bus.val[0]), 40);
    chk({nm, "_val1"}, longint'(bus.val[1]), 96);
    chk({nm, "_ovf"},  longint'(bus.ovf), 0);
    repeat (20) @(negedge clk);
    chk({nm, "_single_done"}, longint'(n_done - d0), 0);
  endtask

  initial begin
    int t0;
    int i;
    longint v1;
    per[0] = 0; per[1] = 0; per[2] = 0;
    hi[0] = 0;  hi[1] = 0;  hi[2] = 0;
    ph[0] = 0;  ph[1] = 0;  ph[2] = 0;
    bus.start  = 1'b0; bus.mode  = 2'd0; bus.nper  = 8'd0;
    bus.abort  = 1'b0;
    bus8.start = 1'b0; bus8.mode = 2'd0; bus8.nper = 8'd0;
    bus8.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_val8", longint'(bus8.val[0]), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Two periods, PERIOD mode, nper=4
    test_basic("t1");

    // Duty 3/10 on both channels
    per[0] = 10; hi[0] = 3;
    per[1] = 10; hi[1] = 3;
    repeat (20) @(negedge clk);
    measure(1, 2, 2'b00, 300);
    chk("t2_high", longint'(bus.val[0]), 6);
    measure(2, 2, 2'b00, 300);
    chk("t2_low", longint'(bus.val[0]), 14);
    measure(0, 0, 2'b00, 300);
    chk("t2_nper0", longint'(bus.val[1]), 10);
    measure(3, 1, 2'b00, 300);
    chk("t2_mode3", longint'(bus.val[0]), 10);

    // 8-bit counter saturation
    per[2] = 100; hi[2] = 50;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    bus8.mode = 2'd0; bus8.nper = 8'd4; bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    i = 0;
    while (!bus8.done && i < 800) begin
      @(negedge clk);
      i++;
    end
    chk("t3_done8", longint'(bus8.done), 1);
    chk("t3_val8", longint'(bus8.val[0]), 255);
    chk("t3_ovf8", longint'(bus8.ovf[0]), 1);
    chk("t3_tmo8", longint'(bus8.tmo[0]), 0);

`ifdef TMEAS_TIMEOUT_EN
    // Stuck channel 0 forced complete by the cycle limit
    per[0] = 0;
    per[1] = 10; hi[1] = 5;
    repeat (10) @(negedge clk);
    t0 = cyc + 1;
    measure(0, 2, 2'b01, 1500);
    chk("t4_tmo", longint'(bus.tmo), 1);
    chk("t4_val0", longint'(bus.val[0]), 0);
    chk("t4_val1", longint'(bus.val[1]), 20);
    chk("t4_latency_ok",
        longint'((done_cyc - (t0 + 2)) >= 995 &&
                 (done_cyc - (t0 + 2)) <= 1010), 1);
`else
    t0 = 0;
`endif

    // Abort 50 cycles into RUN; start during busy is ignored
    per[0] = 0;
    per[1] = 24; hi[1] = 12;
    repeat (10) @(negedge clk);
    exp_armed = 1'b0;
    t0 = n_done;
    pulse_start(0, 4);
    repeat (20) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (29) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("t5_busy_after_abort", longint'(bus.busy), 0);
    chk("t5_val0_cleared", longint'(bus.val[0]), 0);
    v1 = longint'(bus.val[1]);
    chk("t5_val1_partial", longint'(v1 > 0 && v1 <= 50), 1);
    repeat (80) @(negedge clk);
    chk("t5_no_done", longint'(n_done - t0), 0);
    chk("t5_val1_held", longint'(bus.val[1]), v1);

    // start+abort together in IDLE does nothing
    @(posedge clk);
    #1;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    chk("t5_start_abort_idle", longint'(bus.busy), 0);

    // Asynchronous reset mid-RUN, then a clean repeat of test 1
    per[0] = 10; hi[0] = 5;
    per[1] = 24; hi[1] = 12;
    repeat (10) @(negedge clk);
    exp_armed = 1'b0;
    pulse_start(0, 4);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("t6_reset");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    test_basic("t6_rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
